// File: rtl/universal_shifter.sv
// Universal shift register: parallel load plus a multi-step engine shifting one bit per clock.
// Build option UNIVERSAL_SHIFTER_ROTATE_EN adds rotate fill for op=11; otherwise op=11 acts as logical.
module universal_shifter #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             dir,
  input  logic [AMT_W-1:0] amount,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [1:0] OP_ARITH  = 2'b01;
  localparam logic [1:0] OP_SERIAL = 2'b10;
`ifdef UNIVERSAL_SHIFTER_ROTATE_EN
  localparam logic [1:0] OP_ROTATE = 2'b11;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             dir_q, dir_d;
  logic             ser_q, ser_d;
  logic             done_q, done_d;

  // Bit entering the vacated end for one single-bit shift.
  function automatic logic fill_bit(input logic [WIDTH-1:0] cur, input logic [1:0] mode,
                                    input logic left, input logic sin);
    logic f;
    f = 1'b0;
    case (mode)
      OP_ARITH:  f = left ? 1'b0 : cur[WIDTH-1];
      OP_SERIAL: f = sin;
`ifdef UNIVERSAL_SHIFTER_ROTATE_EN
      OP_ROTATE: f = left ? cur[WIDTH-1] : cur[0];
`endif
      default:   f = 1'b0;
    endcase
    return f;
  endfunction

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] cur,
                                                  input logic left, input logic f);
    logic [WIDTH-1:0] r;
    if (left) r = {cur[WIDTH-2:0], f};
    else      r = {f, cur[WIDTH-1:1]};
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dir_d   = dir_q;
    ser_d   = ser_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_en) begin
          data_d = load_val;
        end else if (start) begin
          if (amount == '0) begin
            done_d = 1'b1;
          end else begin
            op_d    = op;
            dir_d   = dir;
            cnt_d   = amount;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        data_d = shift_once(data_q, dir_q, fill_bit(data_q, op_q, dir_q, ser_in));
        ser_d  = dir_q ? data_q[WIDTH-1] : data_q[0];
        cnt_d  = cnt_q - AMT_W'(1);
        // Last shift: return to IDLE so a new command is accepted while done is high.
        if (cnt_q == AMT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      dir_q   <= 1'b0;
      ser_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dir_q   <= dir_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
    end
  end

  assign q       = data_q;
  assign ser_out = ser_q;
  assign busy    = (state_q == SHIFT);
  assign done    = done_q;

endmodule
